// File: rtl/conv_pkg.sv
// Shared frame geometry, read-FSM state encoding and pixel indexing for the
// convolution datapath.
package conv_pkg;
  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int PIX_W   = 8;
  localparam int FRAME_W = ROWS * COLS * PIX_W;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    WAIT_DONE
  } rd_state_e;

  function automatic int pix_idx(input int r, input int c);
    return r * COLS + c;
  endfunction
endpackage

// File: rtl/conv_frame_bank.sv
// One frame of pixel storage: single write port addressed by row/col,
// whole frame visible on a flat read bus.
module conv_frame_bank
  import conv_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we_i,
  input  logic [ROW_W-1:0]        row_i,
  input  logic [COL_W-1:0]        col_i,
  input  logic signed [PIX_W-1:0] pix_i,
  output logic [FRAME_W-1:0]      frame_o
);

  logic [FRAME_W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[pix_idx(int'(row_i), int'(col_i)) * PIX_W +: PIX_W] <= pix_i;
    end
  end

  assign frame_o = mem_q;

endmodule

// File: rtl/conv_frame_loader.sv
// Ping-pong frame loader: fills one bank from the pixel stream while the
// other bank is presented to the convolution stage until it signals done.
module conv_frame_loader #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int PIX_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [PIX_W-1:0]      pix_in,
  input  logic                         pix_valid,
  input  logic                         pix_sof,
  output logic                         pix_ready,
  output logic [ROWS*COLS*PIX_W-1:0]   frame_out,
  output logic                         in_st,
  input  logic                         conv_done,
  output logic                         err_sync
);
  import conv_pkg::*;

  localparam int RCNT_W = $clog2(ROWS);
  localparam int CCNT_W = $clog2(COLS);
  localparam int FW     = ROWS * COLS * PIX_W;

  rd_state_e         state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [RCNT_W-1:0] row_q, row_d, wr_row;
  logic [CCNT_W-1:0] col_q, col_d, wr_col;
  logic              in_st_q, err_q, err_d;
  logic              xfer, last_pix, release_fr;
  logic [FW-1:0]     frame0, frame1;

  assign pix_ready  = ~full_q[wr_bank_q];
  assign xfer       = pix_valid & pix_ready;
  // An SOF pixel always lands at (0,0), whatever the counters say.
  assign wr_row     = pix_sof ? '0 : row_q;
  assign wr_col     = pix_sof ? '0 : col_q;
  assign last_pix   = (wr_row == RCNT_W'(ROWS - 1)) && (wr_col == CCNT_W'(COLS - 1));
  assign release_fr = (state_q == WAIT_DONE) && conv_done;

  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    err_d     = 1'b0;
    if (release_fr) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (xfer) begin
      err_d = pix_sof && ((row_q != '0) || (col_q != '0));
      if (last_pix) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        row_d             = '0;
        col_d             = '0;
      end else if (wr_col == CCNT_W'(COLS - 1)) begin
        row_d = wr_row + 1'b1;
        col_d = '0;
      end else begin
        row_d = wr_row;
        col_d = wr_col + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (full_q[rd_bank_q]) state_d = PRESENT;
      PRESENT:   state_d = WAIT_DONE;
      WAIT_DONE: if (conv_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      in_st_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      row_q     <= row_d;
      col_q     <= col_d;
      in_st_q   <= (state_d == PRESENT);
      err_q     <= err_d;
    end
  end

  conv_frame_bank u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .we_i    (xfer & ~wr_bank_q),
    .row_i   (wr_row),
    .col_i   (wr_col),
    .pix_i   (pix_in),
    .frame_o (frame0)
  );

  conv_frame_bank u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .we_i    (xfer & wr_bank_q),
    .row_i   (wr_row),
    .col_i   (wr_col),
    .pix_i   (pix_in),
    .frame_o (frame1)
  );

  assign frame_out = rd_bank_q ? frame1 : frame0;
  assign in_st     = in_st_q;
  assign err_sync  = err_q;

endmodule

// File: doc/conv_frame_loader.md
Name: conv_frame_loader

Overview:
- Upstream stage of the 2D convolution processor.
- Accepts a raster-order stream of signed 8-bit pixels over a valid/ready handshake and assembles complete 8x8 frames in a ping-pong (two-bank) buffer.
- Presents each finished frame as a flat parallel bus and issues a one-cycle start strobe to the convolution stage.
- Holds that frame stable until the convolution stage reports completion, while the next frame fills the other bank.

Parameters:
- ROWS, 8, frame height in pixels
- COLS, 8, frame width in pixels
- PIX_W, 8, signed pixel width in bits

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- pix_in  input  PIX_W  signed pixel, raster order (row 0 col 0 first)
- pix_valid  input  1  pix_in valid this cycle
- pix_sof  input  1  start-of-frame tag; qualified by pix_valid
- pix_ready  output  1  loader can accept a pixel this cycle
- frame_out  output  ROWS*COLS*PIX_W  presented frame; pixel (r,c) at bits [(r*COLS+c)*PIX_W +: PIX_W]
- in_st  output  1  one-cycle strobe: frame_out is valid, start convolution
- conv_done  input  1  one-cycle pulse from the convolution stage (its out_st): presented frame released
- err_sync  output  1  one-cycle pulse: partial frame discarded on an unexpected SOF

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: in_st=0, err_sync=0, pix_ready=1, both bank-full flags=0, wr_bank=0, rd_bank=0, row/col counters=0, FSM=IDLE, all bank storage=0 (so frame_out=0).
- Reset mid-operation: any partial or full frame is discarded with no strobe.
- Transfer rule: a transfer occurs when pix_valid && pix_ready at a rising edge.
- pix_ready is combinational: pix_ready = ~full[wr_bank].
- Write side:
  - Each transfer writes pix_in to bank wr_bank at (row,col), then advances col; col wraps at COLS-1 and increments row.
  - On the transfer of (ROWS-1,COLS-1): set full[wr_bank], toggle wr_bank, clear row/col.
  - When both banks are full, pix_ready=0 and the stream stalls.
- SOF handling:
  - A transfer with pix_sof=1 always writes at (0,0), then sets col=1.
  - If (row,col) was not (0,0) before that transfer, the partial frame is abandoned and err_sync pulses high for exactly the next cycle.
  - pix_sof is not required; without it frames are delimited by count alone.
- Read-side FSM:
  - IDLE: if full[rd_bank], go to PRESENT.
  - PRESENT: in_st=1 for this single cycle, then go to WAIT_DONE.
  - WAIT_DONE: on conv_done, clear full[rd_bank], toggle rd_bank, go to IDLE.
  - conv_done is ignored in IDLE and PRESENT.
- Output path: in_st is a registered FSM decode. frame_out is the muxed storage of bank rd_bank and is stable from in_st until conv_done.
- Latency: last pixel accepted at edge t gives in_st high during cycle t+2. conv_done at edge t' with the other bank full gives the next in_st during cycle t'+2.
- Simultaneous events:
  - conv_done and the last-pixel transfer into the other bank in the same cycle: both take effect; the next frame is strobed two cycles later.
  - conv_done while both banks are full: pix_ready rises the cycle after that edge.
- Arithmetic: pixels are stored bit-exact with no sign extension or saturation; counters are $clog2(ROWS) and $clog2(COLS) bits.

Decomposition:
- Package conv_pkg:
  - ROWS/COLS/PIX_W constants (shared with the convolution stage)
  - read-FSM state enum {IDLE, PRESENT, WAIT_DONE}
  - frame flat-bus width constant
  - a pixel-index helper function (r*COLS+c)
- Sub-module conv_frame_bank: one ROWS x COLS x PIX_W register array with sync reset, write enable, row/col address and flat read bus. Instantiate twice.
- The top level holds the counters, full flags, SOF logic and read FSM.

Test Plan:
- Reset, then stream 64 pixels valued r*8+c back-to-back -> in_st high for exactly one cycle, 2 cycles after the 64th transfer; frame_out(r,c)=r*8+c; pix_ready stays 1.
- Stream 3 frames with conv_done held low -> pix_ready falls after the 128th transfer and the stream stalls. Pulse conv_done -> frame 2 in_st two cycles later with frame 2 data, and pix_ready returns to 1.
- Send a SOF-tagged pixel after 20 pixels of a frame -> err_sync pulses once; no in_st until 63 further pixels (64 counting the SOF pixel); frame_out(0,0)=the SOF pixel value.
- Assert conv_done in the same cycle as the last-pixel transfer of bank 1 -> bank 0 is released and bank 1's in_st follows 2 cycles later with no lost frame.
- Assert reset after 30 pixels -> in_st=0, pix_ready=1, frame_out=0; the next 64 pixels produce exactly one in_st.
- Stream values -128, -1, 127 at (0,0), (3,5), (7,7) -> identical bit patterns 0x80, 0xFF, 0x7F at the specified frame_out slices.
